// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: input handshake, operands and result handshake.
// Latency: none (wires only).
// Backpressure: in_ready and out_ready carry flow control in each direction.
// Optional: SERIAL_ADDER_OVF_EN adds the out_ovf signed-overflow flag.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one DIGIT-bit full-adder ripple reused over WIDTH/DIGIT cycles.
// Latency: out_valid rises after K = WIDTH/DIGIT RUN edges following the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Optional: SERIAL_ADDER_OVF_EN adds out_ovf (carry into MSB xor carry out of MSB).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus,
  output logic          busy
);

  localparam int K  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 1");
  end
  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dcout;
  logic             w_dcmsb;
  logic [WIDTH-1:0] w_s_next;
  logic             w_accept;
  logic             w_last;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: IDLE accepts, RUN counts digits, DONE waits for the consumer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One digit of ripple-carry; also exposes the carry into the digit's top bit for overflow.
  always_comb begin
    logic v_c;
    w_dsum  = '0;
    w_dcmsb = 1'b0;
    v_c     = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      w_dcmsb   = v_c;
      w_dsum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c       = (r_a[i] & r_b[i]) | (r_a[i] & v_c) | (r_b[i] & v_c);
    end
    w_dcout = v_c;
  end

  // New digit enters at the top of the sum register as the old contents move down.
  assign w_s_next = WIDTH'({w_dsum, r_s} >> DIGIT);

  // Datapath: load operands on accept (B inverted with carry 1 for subtract), shift while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.in_a;
      r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
      r_cnt   <= CW'(K - 1);
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_s     <= w_s_next;
      r_carry <= w_dcout;
      if (w_last) r_cout <= w_dcout;
      else        r_cnt  <= r_cnt - 1'b1;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow of the final digit's MSB, captured on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ovf <= 1'b0;
    else if ((r_state == S_RUN) && w_last) r_ovf <= w_dcmsb ^ w_dcout;
  end

  assign bus.out_ovf = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_dcmsb;
`endif

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_sum   = r_s;
  assign bus.out_cout  = r_cout;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT = 1, 4, 8) on WIDTH = 8, table vectors plus
// backpressure and mid-run reset sequences; results checked through an expected-result queue.
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    int         dut;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] t_a;
  logic [7:0] t_b;
  logic       t_sub;
  logic       t_cin;
  logic [2:0] t_vld;
  logic [2:0] t_ordy;

  wire  [2:0] w_irdy;
  wire  [2:0] w_ovld;
  wire  [2:0] w_cout;
  wire  [2:0] w_busy;
  wire  [2:0] w_ovf;
  wire  [7:0] w_sum0;
  wire  [7:0] w_sum1;
  wire  [7:0] w_sum2;

  int   n_chk;
  int   n_fail;
  exp_t sb_q[$];

  serial_adder_if #(.WIDTH(8)) ifc0 ();
  serial_adder_if #(.WIDTH(8)) ifc1 ();
  serial_adder_if #(.WIDTH(8)) ifc2 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(ifc0), .busy(w_busy[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(ifc1), .busy(w_busy[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(ifc2), .busy(w_busy[2]));

  assign ifc0.in_a = t_a;  assign ifc0.in_b = t_b;  assign ifc0.in_sub = t_sub;  assign ifc0.in_cin = t_cin;
  assign ifc1.in_a = t_a;  assign ifc1.in_b = t_b;  assign ifc1.in_sub = t_sub;  assign ifc1.in_cin = t_cin;
  assign ifc2.in_a = t_a;  assign ifc2.in_b = t_b;  assign ifc2.in_sub = t_sub;  assign ifc2.in_cin = t_cin;
  assign ifc0.in_valid = t_vld[0];  assign ifc0.out_ready = t_ordy[0];
  assign ifc1.in_valid = t_vld[1];  assign ifc1.out_ready = t_ordy[1];
  assign ifc2.in_valid = t_vld[2];  assign ifc2.out_ready = t_ordy[2];

  assign w_irdy = {ifc2.in_ready,  ifc1.in_ready,  ifc0.in_ready};
  assign w_ovld = {ifc2.out_valid, ifc1.out_valid, ifc0.out_valid};
  assign w_cout = {ifc2.out_cout,  ifc1.out_cout,  ifc0.out_cout};
  assign w_sum0 = ifc0.out_sum;
  assign w_sum1 = ifc1.out_sum;
  assign w_sum2 = ifc2.out_sum;
`ifdef SERIAL_ADDER_OVF_EN
  assign w_ovf  = {ifc2.out_ovf, ifc1.out_ovf, ifc0.out_ovf};
`else
  assign w_ovf  = 3'b000;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] sum_of(input int d);
    case (d)
      0:       return w_sum0;
      1:       return w_sum1;
      default: return w_sum2;
    endcase
  endfunction

  function automatic int k_of(input int d);
    case (d)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Scoreboard: every completed output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (w_ovld[d] && t_ordy[d]) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'(d), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result_dut", 32'(d), 32'(e.dut));
            chk("out_sum", 32'(sum_of(d)), 32'(e.sum));
            chk("out_cout", 32'(w_cout[d]), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk("out_ovf", 32'(w_ovf[d]), 32'(e.ovf));
`endif
          end
        end
      end
    end
  end

  // Present operands to DUT d and wait (bounded) for the accepting edge; queue the expectation.
  task automatic present(input int d, input vec_t v);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    t_a = v.a; t_b = v.b; t_sub = v.sub; t_cin = v.cin;
    t_vld[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_irdy[d] && n < 50);
    chk("accept_ready", 32'(w_irdy[d]), 32'd1);
    e.dut = d; e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
    sb_q.push_back(e);
    @(posedge clk); #1;
    t_vld[d] = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_result(input int d);
    int n;
    @(negedge clk);
    chk("busy_in_run", 32'(w_busy[d]), 32'd1);
    chk("ready_in_run", 32'(w_irdy[d]), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!w_ovld[d] && n < 40);
    chk("latency", 32'(n), 32'(k_of(d)));
  endtask

  task automatic do_op(input int d, input vec_t v);
    present(d, v);
    wait_result(d);
    @(negedge clk);
    chk("valid_one_cycle", 32'(w_ovld[d]), 32'd0);
    chk("ready_after_done", 32'(w_irdy[d]), 32'd1);
  endtask

  vec_t tbl[10];
  vec_t v;
  int   seen;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    t_a = '0; t_b = '0; t_sub = 1'b0; t_cin = 1'b0;
    t_vld = '0; t_ordy = 3'b111;

    //            a      b      sub   cin   sum    cout  ovf
    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 8'h02, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[5] = '{8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[8] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0};
    tbl[9] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", 32'(w_ovld[d]), 32'd0);
      chk("rst_busy", 32'(w_busy[d]), 32'd0);
      chk("rst_in_ready", 32'(w_irdy[d]), 32'd1);
      chk("rst_out_sum", 32'(sum_of(d)), 32'd0);
      chk("rst_out_cout", 32'(w_cout[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Table vectors on every digit width.
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 10; i++)
        do_op(d, tbl[i]);

    // Backpressure: result held in DONE, new operands refused until released.
    t_ordy[0] = 1'b0;
    present(0, tbl[0]);
    wait_result(0);
    @(posedge clk); #1;
    t_a = 8'h11; t_b = 8'h22; t_sub = 1'b0; t_cin = 1'b0;
    t_vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(w_ovld[0]), 32'd1);
      chk("bp_sum", 32'(w_sum0), 32'h96);
      chk("bp_cout", 32'(w_cout[0]), 32'd0);
      chk("bp_in_ready", 32'(w_irdy[0]), 32'd0);
    end
    @(posedge clk); #1;
    t_ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_ready_at_release", 32'(w_irdy[0]), 32'd0);
    @(negedge clk);
    chk("bp_idle_ready", 32'(w_irdy[0]), 32'd1);
    chk("bp_idle_valid", 32'(w_ovld[0]), 32'd0);
    v = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
    sb_q.push_back('{0, v.sum, v.cout, v.ovf});
    @(posedge clk); #1;
    t_vld[0] = 1'b0;
    wait_result(0);
    @(negedge clk);

    // Reset after the third RUN cycle: pending result discarded.
    @(posedge clk); #1;
    t_a = 8'h5A; t_b = 8'h3C; t_sub = 1'b0; t_cin = 1'b0;
    t_vld[0] = 1'b1;
    @(negedge clk);
    chk("mr_accept_ready", 32'(w_irdy[0]), 32'd1);
    @(posedge clk); #1;
    t_vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(w_ovld[0]), 32'd0);
    chk("mr_busy", 32'(w_busy[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (w_ovld[0]) seen++;
    end
    chk("mr_no_stale_result", 32'(seen), 32'd0);
    do_op(0, tbl[4]);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
